// File: rtl/axi_bridge_pkg.sv
// Shared definitions for the SRAM-like-to-AXI bridge.
// Provides:
//   - the AXI ID values that select the instruction and data ports
//   - the OKAY response code
//   - the fixed AR attributes driven by the address stage
//   - the R-stage control state type
package axi_bridge_pkg;

  localparam logic [3:0] ID_INST       = 4'd0;
  localparam logic [3:0] ID_DATA       = 4'd1;
  localparam logic [1:0] RESP_OKAY     = 2'b00;
  localparam logic [7:0] AR_LEN        = 8'd0;
  localparam logic [1:0] AR_BURST_INCR = 2'b01;

  typedef enum logic {
    R_RST = 1'b0,
    R_RUN = 1'b1
  } r_state_e;

endpackage

// File: rtl/axi_rd_outst_cnt.sv
// Outstanding-read counter for one AXI read ID.
// Ports:
//   clk, reset : bridge clock; synchronous active-high reset
//   inc        : an AR was accepted on this ID
//   dec        : an R beat was consumed on this ID
//   full       : counter equals MAX_OUTST
//   nonzero    : at least one read is outstanding
//   err        : combinational pulse on overflow or underflow attempt
module axi_rd_outst_cnt #(
  parameter int MAX_OUTST = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic nonzero,
  output logic err
);

  localparam int              CNT_W   = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTST);

  logic [CNT_W-1:0] count;

  // Saturating step: an increment at the ceiling or a decrement at zero
  // leaves the count untouched; simultaneous inc and dec cancel.
  function automatic logic [CNT_W-1:0] sat_step(
    input logic [CNT_W-1:0] c,
    input logic             up,
    input logic             dn
  );
    sat_step = c;
    if (up && !dn && (c != MAX_CNT))
      sat_step = c + CNT_W'(1);
    else if (dn && !up && (c != '0))
      sat_step = c - CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else
      count <= sat_step(count, inc, dec);
  end

  assign full    = (count == MAX_CNT);
  assign nonzero = (count != '0);
  assign err     = (inc && !dec && (count == MAX_CNT)) ||
                   (dec && !inc && (count == '0));

endmodule

// File: rtl/axi_r_resp.sv
// Read-data (R) channel stage of the SRAM-like-to-AXI bridge.
// Routes AXI R beats to the instruction or data CPU port as a one-cycle
// data_ok pulse with registered read data, tracks outstanding reads per ID
// and keeps a sticky protocol-error flag.
// Ports:
//   clk, reset              : bridge clock; synchronous active-high reset
//   ar_fire, ar_id          : accepted AR handshake and its ID
//   ar_stall[1:0]           : per-ID outstanding limit reached
//   rid/rdata/rresp/rlast/rvalid, rready : AXI R channel
//   inst_data_ok/inst_rdata : instruction port read return
//   data_data_ok/data_rdata : data port read return
//   rd_pending[1:0]         : per-ID reads outstanding
//   r_err                   : sticky protocol-error flag
module axi_r_resp
  import axi_bridge_pkg::*;
#(
  parameter int MAX_OUTST = 3,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ar_fire,
  input  logic [3:0]        ar_id,
  output logic [1:0]        ar_stall,
  input  logic [3:0]        rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic [1:0]        rd_pending,
  output logic              r_err
);

  r_state_e          state, state_nxt;
  logic              r_fire;
  logic              sel_inst;
  logic [1:0]        inc, dec, cnt_full, cnt_nz, cnt_err;
  logic              beat_bad;
  logic              inst_vld_p1, data_vld_p1;
  logic [DATA_W-1:0] inst_rdata_p1, data_rdata_p1;
  logic              r_err_q;

  // Only bit 0 of ar_id selects a counter; the upper bits carry no routing.
  logic unused_ar_id_hi;
  assign unused_ar_id_hi = |ar_id[3:1];

  always_ff @(posedge clk) begin
    if (reset)
      state <= R_RST;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rready    = 1'b0;
    case (state)
      R_RST: state_nxt = R_RUN;
      R_RUN: rready    = 1'b1;
      default: state_nxt = R_RST;
    endcase
  end

  // Stage p0: handshake decode and counter bookkeeping
  assign r_fire   = rvalid && rready;
  assign sel_inst = (rid[0] == ID_INST[0]);

  assign inc[0] = ar_fire && (ar_id[0] == ID_INST[0]);
  assign inc[1] = ar_fire && (ar_id[0] == ID_DATA[0]);
  assign dec[0] = r_fire && sel_inst;
  assign dec[1] = r_fire && !sel_inst;

  for (genvar i = 0; i < 2; i++) begin : g_cnt
    axi_rd_outst_cnt #(
      .MAX_OUTST (MAX_OUTST)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .full    (cnt_full[i]),
      .nonzero (cnt_nz[i]),
      .err     (cnt_err[i])
    );
  end

  assign ar_stall   = cnt_full;
  assign rd_pending = cnt_nz;

  // A beat is malformed if it is not OKAY, not the last beat, or carries an ID
  // outside the two ports this bridge issues.
  assign beat_bad = r_fire && ((rresp != RESP_OKAY) || !rlast || (rid[3:1] != 3'd0));

  // Stage p1: registered port returns and sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_vld_p1   <= 1'b0;
      data_vld_p1   <= 1'b0;
      inst_rdata_p1 <= '0;
      data_rdata_p1 <= '0;
      r_err_q       <= 1'b0;
    end else begin
      inst_vld_p1 <= dec[0];
      data_vld_p1 <= dec[1];
      if (dec[0])
        inst_rdata_p1 <= rdata;
      if (dec[1])
        data_rdata_p1 <= rdata;
      if (beat_bad || (|cnt_err))
        r_err_q <= 1'b1;
    end
  end

  assign inst_data_ok = inst_vld_p1;
  assign inst_rdata   = inst_rdata_p1;
  assign data_data_ok = data_vld_p1;
  assign data_rdata   = data_rdata_p1;
  assign r_err        = r_err_q;

endmodule

// File: tb/tb_axi_r_resp.sv
module tb_axi_r_resp;

  localparam int MAXO = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        ar_fire;
  logic [3:0]  ar_id;
  logic [1:0]  ar_stall;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic [1:0]  rd_pending;
  logic        r_err;

  int checks   = 0;
  int failures = 0;

  // Reference model state: outstanding reads per port, sticky error,
  // ready flag and the last value delivered to each port.
  int          m_cnt [2];
  bit          m_err, m_rdy, m_iok, m_dok;
  logic [31:0] m_ird, m_drd;

  always #5 clk = ~clk;

  axi_r_resp dut (
    .clk          (clk),
    .reset        (reset),
    .ar_fire      (ar_fire),
    .ar_id        (ar_id),
    .ar_stall     (ar_stall),
    .rid          (rid),
    .rdata        (rdata),
    .rresp        (rresp),
    .rlast        (rlast),
    .rvalid       (rvalid),
    .rready       (rready),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .rd_pending   (rd_pending),
    .r_err        (r_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock using the inputs presented at this edge.
  task automatic model_step();
    bit fire, bad;
    int sel, aid;
    if (reset) begin
      m_cnt[0] = 0; m_cnt[1] = 0;
      m_err = 0; m_rdy = 0; m_iok = 0; m_dok = 0;
      m_ird = 0; m_drd = 0;
    end else begin
      fire = rvalid && m_rdy;
      sel  = int'(rid) % 2;
      aid  = int'(ar_id) % 2;
      for (int i = 0; i < 2; i++) begin
        bit up, dn;
        up = ar_fire && (aid == i);
        dn = fire && (sel == i);
        if (up && !dn) begin
          if (m_cnt[i] == MAXO) m_err = 1;
          else m_cnt[i]++;
        end else if (dn && !up) begin
          if (m_cnt[i] == 0) m_err = 1;
          else m_cnt[i]--;
        end
      end
      bad = fire && (rresp != 2'b00 || !rlast || (int'(rid) / 2) != 0);
      if (bad) m_err = 1;
      m_iok = fire && (sel == 0);
      m_dok = fire && (sel == 1);
      if (m_iok) m_ird = rdata;
      if (m_dok) m_drd = rdata;
      m_rdy = 1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] st, pd;
    st = {m_cnt[1] == MAXO, m_cnt[0] == MAXO};
    pd = {m_cnt[1] != 0, m_cnt[0] != 0};
    check({tag, ".rready"},     32'(rready),       32'(m_rdy));
    check({tag, ".inst_ok"},    32'(inst_data_ok), 32'(m_iok));
    check({tag, ".inst_rdata"}, inst_rdata,        m_ird);
    check({tag, ".data_ok"},    32'(data_data_ok), 32'(m_dok));
    check({tag, ".data_rdata"}, data_rdata,        m_drd);
    check({tag, ".ar_stall"},   32'(ar_stall),     32'(st));
    check({tag, ".rd_pending"}, 32'(rd_pending),   32'(pd));
    check({tag, ".r_err"},      32'(r_err),        32'(m_err));
  endtask

  task automatic idle_inputs();
    reset = 0; ar_fire = 0; ar_id = 0;
    rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1;
  endtask

  // Clock once with the currently driven inputs, then check, then go idle.
  task automatic cycle(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
    idle_inputs();
  endtask

  task automatic do_reset(input string tag);
    idle_inputs(); reset = 1; cycle({tag, ".rst"});
    cycle({tag, ".rel"});
  endtask

  task automatic set_ar(input logic [3:0] id);
    ar_fire = 1; ar_id = id;
  endtask

  task automatic set_r(input logic [3:0] id, input logic [31:0] d,
                       input logic [1:0] resp, input logic last);
    rvalid = 1; rid = id; rdata = d; rresp = resp; rlast = last;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_err = 0; m_rdy = 0; m_iok = 0; m_dok = 0; m_ird = 0; m_drd = 0;

    // Reset then idle
    reset = 1; cycle("rst0");
    reset = 1; cycle("rst1");
    check("rst.rready_low", 32'(rready), 32'd0);
    cycle("rel0");
    check("rel.rready_high", 32'(rready), 32'd1);
    cycle("idle0");
    cycle("idle1");

    // Single data read
    set_ar(4'd1); cycle("dr.ar");
    check("dr.pending1", 32'(rd_pending), 32'b10);
    set_r(4'd1, 32'hDEADBEEF, 2'b00, 1'b1); cycle("dr.r");
    check("dr.data_ok", 32'(data_data_ok), 32'd1);
    check("dr.rdata", data_rdata, 32'hDEADBEEF);
    cycle("dr.after");
    check("dr.pending0", 32'(rd_pending), 32'b00);

    // Saturation on ID 0
    for (int k = 0; k < 3; k++) begin
      set_ar(4'd0); cycle("sat.ar");
    end
    check("sat.stall", 32'(ar_stall), 32'b01);
    check("sat.err_clear", 32'(r_err), 32'd0);
    set_ar(4'd0); cycle("sat.over");
    check("sat.err_set", 32'(r_err), 32'd1);
    check("sat.still_full", 32'(ar_stall), 32'b01);

    // Simultaneous inc and dec
    do_reset("sim");
    set_ar(4'd0); cycle("sim.ar");
    set_ar(4'd0); set_r(4'd0, 32'h1234_5678, 2'b00, 1'b1); cycle("sim.both");
    check("sim.iok", 32'(inst_data_ok), 32'd1);
    check("sim.err", 32'(r_err), 32'd0);
    check("sim.pending", 32'(rd_pending), 32'b01);
    set_r(4'd0, 32'h0BAD_F00D, 2'b00, 1'b1); cycle("sim.drain");

    // Non-OKAY response: data delivered, error sticky
    do_reset("resp");
    set_ar(4'd0); cycle("resp.ar");
    set_r(4'd0, 32'hCAFE_0001, 2'b10, 1'b1); cycle("resp.r");
    check("resp.err", 32'(r_err), 32'd1);
    check("resp.rdata", inst_rdata, 32'hCAFE_0001);
    cycle("resp.sticky");

    // Missing rlast
    do_reset("last");
    set_ar(4'd1); cycle("last.ar");
    set_r(4'd1, 32'h5A5A_5A5A, 2'b00, 1'b0); cycle("last.r");

    // Unexpected rid with zero count
    do_reset("unx");
    set_r(4'd1, 32'h7777_0000, 2'b00, 1'b1); cycle("unx.r");
    check("unx.err", 32'(r_err), 32'd1);
    check("unx.dok", 32'(data_data_ok), 32'd1);

    // Interleaved beats, back to back
    do_reset("ilv");
    set_ar(4'd0); cycle("ilv.ar0");
    set_ar(4'd1); cycle("ilv.ar1");
    set_r(4'd0, 32'hAAAA_0000, 2'b00, 1'b1); cycle("ilv.r0");
    set_r(4'd1, 32'hBBBB_1111, 2'b00, 1'b1); cycle("ilv.r1");
    check("ilv.dok", 32'(data_data_ok), 32'd1);
    check("ilv.iok_off", 32'(inst_data_ok), 32'd0);
    check("ilv.irdata_held", inst_rdata, 32'hAAAA_0000);

    // Reset mid-flight drops outstanding reads
    do_reset("mid");
    set_ar(4'd0); cycle("mid.ar0");
    set_ar(4'd1); cycle("mid.ar1");
    reset = 1; cycle("mid.rst");
    check("mid.rready_low", 32'(rready), 32'd0);
    check("mid.pending", 32'(rd_pending), 32'b00);
    cycle("mid.rel");
    set_r(4'd0, 32'h0000_00EE, 2'b00, 1'b1); cycle("mid.stale");
    check("mid.stale_err", 32'(r_err), 32'd1);

    // Randomized traffic against the model
    do_reset("rnd");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 79) == 0) begin
        reset = 1;
      end else begin
        if ($urandom_range(0, 2) == 0) begin
          ar_id = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
          ar_fire = (m_cnt[int'(ar_id) % 2] < MAXO) || ($urandom_range(0, 9) == 0);
        end
        if ($urandom_range(0, 1) == 0) begin
          rid = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'($urandom_range(0, 1));
          rvalid = (m_cnt[int'(rid) % 2] > 0) || ($urandom_range(0, 9) == 0);
          rdata  = $urandom;
          rresp  = ($urandom_range(0, 29) == 0) ? 2'($urandom) : 2'b00;
          rlast  = ($urandom_range(0, 29) != 0);
        end
      end
      cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_r_resp.md
Name: axi_r_resp

Overview:
- Read-data (R) channel stage of the SRAM-like-to-AXI bridge; sits directly downstream of the read-address stage.
- Consumes AXI R beats and routes them to the CPU instruction or data port as a one-cycle data_ok pulse with registered rdata.
- Tracks outstanding reads per AXI ID so the address stage can be throttled.
- Flags protocol errors: unexpected rid, non-OKAY rresp, missing rlast.

Parameters:
- MAX_OUTST, 3, maximum outstanding reads per ID; counter width is clog2(MAX_OUTST+1).

Ports:
- clk  in  1  bridge clock
- reset  in  1  synchronous, active-high reset
- ar_fire  in  1  AR handshake this cycle (arvalid && arready)
- ar_id  in  4  arid of the accepted AR; 0 = inst, 1 = data
- ar_stall  out  2  bit i high when the ID-i counter equals MAX_OUTST; AR stage must not issue on that ID
- rid  in  4  AXI read ID
- rdata  in  32  AXI read data
- rresp  in  2  AXI read response
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI read valid
- rready  out  1  AXI read ready
- inst_data_ok  out  1  one-cycle pulse: inst read data valid
- inst_rdata  out  32  inst read data
- data_data_ok  out  1  one-cycle pulse: data read data valid
- data_rdata  out  32  data read data
- rd_pending  out  2  bit i high when the ID-i counter is nonzero; write side uses this for RAW ordering
- r_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (reset high at a clk edge) clears the following: both counters = 0, rready = 0, inst_data_ok = data_data_ok = 0, inst_rdata = data_rdata = 0, r_err = 0, ar_stall = 0, rd_pending = 0.
- Reset mid-operation drops all in-flight state. Any R beat arriving later for a cleared ID is treated as unexpected.
- rready is registered: 0 during reset, 1 from the first cycle after reset deasserts. It then stays 1, because CPU ports consume data_ok unconditionally.
- r_fire = rvalid && rready. Only rid[0] is decoded: rid[0] = 0 selects inst, 1 selects data.
- Latency:
  - r_fire at edge N raises the selected *_data_ok for exactly one cycle after edge N.
  - The matching *_rdata register loads rdata at edge N and holds it until the next fire on that port.
  - The unselected port's data_ok stays 0.
- Back-to-back beats produce consecutive data_ok pulses with no bubble.
- Counters, per ID i:
  - inc_i = ar_fire && ar_id[0] == i; dec_i = r_fire && rid[0] == i.
  - inc only: +1. dec only: -1. Both in the same cycle: unchanged.
  - inc while count == MAX_OUTST: count saturates and r_err is set (upstream violated ar_stall).
  - dec while count == 0: count stays 0, r_err is set, and data_ok is still pulsed.
- ar_stall[i] = (count_i == MAX_OUTST); rd_pending[i] = (count_i != 0). Both are combinational from the counters.
- r_err is set on r_fire when any of these hold: rresp != OKAY, rlast == 0, or rid[3:1] != 0. It also sets on the counter violations above. It clears only on reset.
- No FSM beyond the reset→run transition of rready. States: RST (rready = 0) → RUN (rready = 1) on the first cycle with reset = 0; any reset returns to RST.

Decomposition:
- Shared package axi_bridge_pkg holds:
  - ID_INST = 4'd0, ID_DATA = 4'd1
  - RESP_OKAY = 2'b00
  - the fixed AR constants (len 0, burst INCR) already used by the address stage
- One sub-module: axi_rd_outst_cnt (inc, dec, count, full, nonzero, overflow/underflow error), instantiated twice.

Test Plan:
- Reset then idle: after reset release, rready = 1 in the next cycle; all other outputs are 0; no data_ok pulse.
- Single data read:
  - Stimulus: ar_fire, ar_id = 1; next cycle rvalid, rid = 1, rdata = 0xDEADBEEF, rresp = 0, rlast = 1.
  - Response: data_data_ok = 1 for one cycle with data_rdata = 0xDEADBEEF; rd_pending[1] goes 1→0; inst_data_ok stays 0.
- Saturation:
  - Stimulus: three ar_fire on ID 0.
  - Response: ar_stall[0] = 1. A fourth ar_fire sets r_err = 1 and the count stays 3.
- Simultaneous events:
  - Stimulus: count_0 = 1; ar_fire ID 0 and r_fire rid = 0 in the same cycle.
  - Response: count stays 1, inst_data_ok pulses, r_err = 0.
- Errors:
  - rresp = 2'b10 on a valid beat → r_err = 1 sticky, data still delivered.
  - rid = 1 with count_1 = 0 → r_err = 1.
  - Interleaved inst/data beats on consecutive cycles → two consecutive pulses, each on the correct port with the correct data.
- Reset mid-flight:
  - Stimulus: two reads outstanding; assert reset for 1 cycle.
  - Response: counters = 0, rready = 0 for that cycle and 1 after release; a stale rid = 0 beat then sets r_err.
